// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the restoring divider
// Purpose: state encoding, datapath width and divide-by-zero quotient value.
// Ports: none (package).
package div_pkg;

   localparam int DIV_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [DIV_W-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/sub_9bit.sv
// rtl/sub_9bit.sv - 9-bit ripple subtractor built from adder/subtractor cells
// Purpose: diff = a - b using a chain of add/sub cells fixed in subtract mode.
// Ports: a, b   - 9-bit operands
//        diff   - 9-bit two's-complement difference
//        borrow - high when a < b (inverse of the final carry)
module sub_9bit (
   input  logic [8:0] a,
   input  logic [8:0] b,
   output logic [8:0] diff,
   output logic       borrow
);

   // Subtract mode: b is inverted in each cell and the chain carry-in is 1.
   localparam logic OP = 1'b1;

   logic [9:0] carry;

   assign carry[0] = OP;

   for (genvar i = 0; i < 9; i++) begin : g_cell
      logic b_x;
      assign b_x        = b[i] ^ OP;
      assign diff[i]    = a[i] ^ b_x ^ carry[i];
      assign carry[i+1] = (a[i] & b_x) | (carry[i] & (a[i] ^ b_x));
   end

   assign borrow = ~carry[9];

endmodule

// File: rtl/restoring_divider_8bit.sv
// rtl/restoring_divider_8bit.sv - sequential unsigned restoring divider, one quotient bit per clock
// Purpose: computes dividend / divisor over WIDTH iterations; divisor 0 completes at once.
// Ports: clk, rst_n (async active-low)
//        start               - request, sampled only while idle
//        dividend, divisor   - operands captured on an accepted start
//        quotient, remainder - results, held until the next accepted start
//        busy                - high while iterating
//        done                - one-cycle completion pulse
//        div_by_zero         - last operation had a zero divisor
module restoring_divider_8bit
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   state_t state_q, state_d;

   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quo_reg;
   logic [WIDTH-1:0] d_reg;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;
   logic [WIDTH:0]   rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // A restored partial remainder is always below the divisor, so its MSB
   // is never set; it exists only to match the subtractor width.
   logic unused_rem_msb;
   assign unused_rem_msb = rem_reg[WIDTH];

   assign shifted = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};

   sub_9bit u_sub (
      .a      (shifted),
      .b      ({1'b0, d_reg}),
      .diff   (trial),
      .borrow (borrow)
   );

   // Borrow means the trial went negative: keep the shifted value, emit 0.
   assign rem_nxt = borrow ? shifted : trial;
   assign quo_nxt = {quo_reg[WIDTH-2:0], ~borrow};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (divisor == '0) ? DONE : CALC;
            end
         end
         CALC: begin
            if (cnt == LAST_ITER) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_reg     <= '0;
         quo_reg     <= '0;
         d_reg       <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  d_reg   <= divisor;
                  quo_reg <= dividend;
                  rem_reg <= '0;
                  cnt     <= '0;
                  if (divisor == '0) begin
                     quotient    <= DIV0_QUOTIENT;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     div_by_zero <= 1'b0;
                  end
               end
            end
            CALC: begin
               rem_reg <= rem_nxt;
               quo_reg <= quo_nxt;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == LAST_ITER) begin
                  quotient  <= quo_nxt;
                  remainder <= rem_nxt[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state_q == CALC);
   assign done = (state_q == DONE);

endmodule

// File: tb/tb_restoring_divider_8bit.sv
// tb/tb_restoring_divider_8bit.sv - directed-vector bench for restoring_divider_8bit
module tb_restoring_divider_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic [7:0] quotient;
   logic [7:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_vec = 0;
   int n_err = 0;

   restoring_divider_8bit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Negedges from now until done is seen (inclusive); 99 if it never comes.
   task automatic wait_done(output int n);
      n = 99;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done) begin
            n = i;
            break;
         end
      end
   endtask

   // One operation issued with a single-cycle start pulse; expected results
   // come from the bench's own division model.
   task automatic run_op(input logic [7:0] dd, input logic [7:0] dv, input string tag);
      logic [7:0] exp_q, exp_r;
      logic       exp_z;
      int         exp_lat, exp_busy, lat, nbusy;
      if (dv == 0) begin
         exp_q = 8'hFF; exp_r = dd; exp_z = 1'b1; exp_lat = 0; exp_busy = 0;
      end else begin
         exp_q = dd / dv; exp_r = dd % dv; exp_z = 1'b0; exp_lat = 8; exp_busy = 8;
      end
      @(negedge clk);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat   = -1;
      nbusy = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            lat = i;
            break;
         end
         if (busy) nbusy++;
      end
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " busy_cycles"}, nbusy, exp_busy);
      chk({tag, " quotient"}, quotient, exp_q);
      chk({tag, " remainder"}, remainder, exp_r);
      chk({tag, " div_by_zero"}, div_by_zero, exp_z);
      if (dv != 0) chk({tag, " q*d+r"}, 32'(quotient) * 32'(dv) + 32'(remainder), dd);
      @(negedge clk);
      chk({tag, " done_single"}, done, 0);
      chk({tag, " quotient_held"}, quotient, exp_q);
      chk({tag, " remainder_held"}, remainder, exp_r);
   endtask

   initial begin
      int n, ndone;
      logic [7:0] cq, cr;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst quotient", quotient, 0);
      chk("rst remainder", remainder, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst div_by_zero", div_by_zero, 0);
      rst_n = 1'b1;

      run_op(8'd200, 8'd7, "200/7");
      run_op(8'd77, 8'd0, "77/0");

      // Back-to-back with start held high
      @(negedge clk);
      dividend = 8'd255; divisor = 8'd1; start = 1'b1;
      wait_done(n);
      chk("b2b 255/1 wait", n, 9);
      chk("b2b 255/1 quotient", quotient, 255);
      chk("b2b 255/1 remainder", remainder, 0);
      dividend = 8'd5; divisor = 8'd9;
      wait_done(n);
      chk("b2b 5/9 gap", n, 10);
      chk("b2b 5/9 quotient", quotient, 0);
      chk("b2b 5/9 remainder", remainder, 5);
      dividend = 8'd255; divisor = 8'd255;
      wait_done(n);
      chk("b2b 255/255 gap", n, 10);
      chk("b2b 255/255 quotient", quotient, 1);
      chk("b2b 255/255 remainder", remainder, 0);
      start = 1'b0;
      repeat (2) @(negedge clk);

      // Operand changes and start pulses while calculating
      @(negedge clk);
      dividend = 8'd100; divisor = 8'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      dividend = 8'd50; divisor = 8'd5; start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      ndone = 0; cq = '0; cr = '0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            cq = quotient;
            cr = remainder;
         end
      end
      chk("midop done_count", ndone, 1);
      chk("midop quotient", cq, 33);
      chk("midop remainder", cr, 1);

      // Asynchronous reset during iteration 4
      @(negedge clk);
      dividend = 8'd200; divisor = 8'd7; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst quotient", quotient, 0);
      chk("arst remainder", remainder, 0);
      chk("arst busy", busy, 0);
      chk("arst done", done, 0);
      chk("arst div_by_zero", div_by_zero, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("arst no_done", ndone, 0);
      run_op(8'd9, 8'd2, "9/2");

      // Boundaries and random sweep
      run_op(8'd0, 8'd5, "0/5");
      run_op(8'd0, 8'd0, "0/0");
      run_op(8'd128, 8'd128, "128/128");
      run_op(8'd254, 8'd255, "254/255");
      for (int i = 0; i < 400; i++) begin
         run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
